lcd_write_sequencer: RTL
========================

Name: lcd_write_sequencer

Overview:
- Sequences one byte write to an HD44780-compatible LCD over its 4-bit bus: upper nibble, then lower nibble, then the mandatory command-execution wait.
- Enable pulses and all timing are generated from an internal cycle counter.
- Sits between the init/refresh FSM (the requester, via a valid/ready handshake) and the LCD pins.
- With default parameters at 50 MHz, a normal write occupies exactly 2080 cycles (41.6 us), matching the system character slot period.

Parameters:
- SETUP_CYC, 2, cycles with data/RS stable before the E rising edge (>=1)
- ENABLE_CYC, 12, cycles E is held high per nibble (>=1)
- HOLD_CYC, 1, cycles data/RS held after the E falling edge (>=1)
- GAP_CYC, 50, cycles between the upper-nibble hold and the lower-nibble setup (>=1)
- CMD_WAIT, 2000, post-write wait cycles for normal writes (>=1)
- LONG_WAIT, 82000, post-write wait cycles for clear/return-home commands (>=1)
- CNT_W, 17, internal counter width; must hold max(LONG_WAIT, CMD_WAIT, GAP_CYC)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (sampled on the rising edge of clk)
- wr_valid  in  1  requester has a write pending
- wr_data  in  8  byte to write
- wr_rs  in  1  register select (0 = command, 1 = data)
- wr_nib_only  in  1  send the upper nibble only (power-up init); skip the gap and lower nibble
- wr_ready  out  1  sequencer idle and able to accept a write
- done  out  1  one-cycle pulse when a write, including its wait, completes
- lcd_e  out  1  LCD enable
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  LCD read/write; tied to 0
- lcd_d  out  4  LCD data nibble

Behaviour:
- Reset (reset=0 at a clk edge):
  - next state IDLE; counter = 0
  - lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_d=0, done=0
  - wr_ready=0 while reset is low
  - applies mid-transfer: an in-flight write is abandoned, E drops at that edge, and no done pulse is issued.
- All outputs except wr_ready are registered. wr_ready = (state==IDLE) & reset.
- Accept: the edge where wr_valid & wr_ready. At that edge, latch data, rs, nib_only and the long-wait flag.
  - long flag = (rs==0) & (data[7:2]==0) & (data[1:0]!=0), i.e. commands 0x01, 0x02, 0x03.
  - Inputs are ignored whenever wr_ready=0.
- States, in order; each lasts its parameter count in cycles:
  - UP_SETUP (SETUP_CYC): lcd_d=data[7:4], lcd_rs=rs, lcd_e=0
  - UP_EN (ENABLE_CYC): lcd_e=1
  - UP_HOLD (HOLD_CYC): lcd_e=0, lcd_d/lcd_rs held
  - GAP (GAP_CYC): lcd_e=0, lcd_d=0
  - LO_SETUP (SETUP_CYC): lcd_d=data[3:0], lcd_e=0
  - LO_EN (ENABLE_CYC): lcd_e=1
  - LO_HOLD (HOLD_CYC): lcd_e=0
  - WAIT (CMD_WAIT, or LONG_WAIT if long flag): lcd_e=0, lcd_d=0, lcd_rs=0
  - then IDLE
- nib_only: UP_HOLD goes directly to WAIT; the wait is always CMD_WAIT.
- Counter: loads 0 on every state entry and counts up. The state advances when counter == param-1.
- Timing (cycle 1 = first cycle after the accept edge, defaults):
  - normal write: UP_SETUP 1-2, UP_EN 3-14, UP_HOLD 15, GAP 16-65, LO_SETUP 66-67, LO_EN 68-79, LO_HOLD 80, WAIT 81-2080
  - cycle 2081: IDLE with done=1 and wr_ready=1
  - long command: busy for 80+82000 = 82080 cycles
  - nib_only: busy for 15+2000 = 2015 cycles
- done=1 for exactly one cycle, the first IDLE cycle after WAIT. A new write may be accepted in that same cycle (back-to-back); done is still a single pulse.
- lcd_e is never high in any state except UP_EN and LO_EN. lcd_d and lcd_rs never change while lcd_e=1.
- Back-pressure: wr_valid held high across a busy period leaves the pending write unaccepted until IDLE; exactly one accept per IDLE entry.

Test Plan:
- Release reset, pulse wr_valid with data=0x48, rs=1, nib_only=0 -> E high cycles 3-14 with lcd_d=4, rs=1; E high cycles 68-79 with lcd_d=8; done=1 at cycle 2081; wr_ready low cycles 1-2080.
- Write data=0x01, rs=0 -> second E pulse as above; done at cycle 82081; long wait also taken for 0x02 and 0x03; 0x04 with rs=0 and 0x01 with rs=1 -> done at cycle 2081.
- nib_only=1 with data=0x30 -> single E pulse cycles 3-14 with lcd_d=3; no GAP or lower nibble; done at cycle 2016.
- Hold wr_valid=1 with 3 queued bytes -> accepts exactly at each done cycle; inter-accept spacing of 2081 cycles; changes to wr_data while busy do not alter lcd_d.
- Assert reset=0 at cycle 10 (E high) -> lcd_e=0 and all outputs 0 after that edge; no done pulse; after release wr_ready=1 and a fresh write behaves as in the first scenario.
- Across all runs, check that lcd_rw is always 0 and that lcd_d/lcd_rs never change while lcd_e=1.

Source files
------------

// File: rtl/lcd_write_sequencer.sv
// Drives one HD44780 byte write over the 4-bit bus: upper nibble, lower nibble,
// then the command-execution wait. Requester handshakes via wr_valid/wr_ready.
module lcd_write_sequencer #(
  parameter int SETUP_CYC  = 2,
  parameter int ENABLE_CYC = 12,
  parameter int HOLD_CYC   = 1,
  parameter int GAP_CYC    = 50,
  parameter int CMD_WAIT   = 2000,
  parameter int LONG_WAIT  = 82000,
  parameter int CNT_W      = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  input  logic       wr_rs,
  input  logic       wr_nib_only,
  output logic       wr_ready,
  output logic       done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] lcd_d
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_UP_SETUP,
    S_UP_EN,
    S_UP_HOLD,
    S_GAP,
    S_LO_SETUP,
    S_LO_EN,
    S_LO_HOLD,
    S_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] ENABLE_LAST = CNT_W'(ENABLE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LAST    = CNT_W'(CMD_WAIT - 1);
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_WAIT - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [7:0]       data_reg, data_next;
  logic             rs_reg, rs_next;
  logic             nib_reg, nib_next;
  logic             long_reg, long_next;
  logic             lcd_e_reg, lcd_e_next;
  logic             lcd_rs_reg, lcd_rs_next;
  logic [3:0]       lcd_d_reg, lcd_d_next;
  logic             done_reg, done_next;
  logic [CNT_W-1:0] wait_last;

  assign wr_ready = (state_reg == S_IDLE) & reset;
  assign done     = done_reg;
  assign lcd_e    = lcd_e_reg;
  assign lcd_rs   = lcd_rs_reg;
  assign lcd_d    = lcd_d_reg;
  assign lcd_rw   = 1'b0;

  // Clear/return-home need the long wait, but an init nibble never does.
  assign wait_last = (long_reg & ~nib_reg) ? LONG_LAST : CMD_LAST;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CNT_W'(1);
    data_next  = data_reg;
    rs_next    = rs_reg;
    nib_next   = nib_reg;
    long_next  = long_reg;

    case (state_reg)
      S_IDLE: begin
        cnt_next = '0;
        if (wr_valid && wr_ready) begin
          state_next = S_UP_SETUP;
          data_next  = wr_data;
          rs_next    = wr_rs;
          nib_next   = wr_nib_only;
          long_next  = ~wr_rs & (wr_data[7:2] == 6'd0) & (wr_data[1:0] != 2'd0);
        end
      end
      S_UP_SETUP: if (cnt_reg == SETUP_LAST)  state_next = S_UP_EN;
      S_UP_EN:    if (cnt_reg == ENABLE_LAST) state_next = S_UP_HOLD;
      S_UP_HOLD:  if (cnt_reg == HOLD_LAST)   state_next = nib_reg ? S_WAIT : S_GAP;
      S_GAP:      if (cnt_reg == GAP_LAST)    state_next = S_LO_SETUP;
      S_LO_SETUP: if (cnt_reg == SETUP_LAST)  state_next = S_LO_EN;
      S_LO_EN:    if (cnt_reg == ENABLE_LAST) state_next = S_LO_HOLD;
      S_LO_HOLD:  if (cnt_reg == HOLD_LAST)   state_next = S_WAIT;
      S_WAIT:     if (cnt_reg == wait_last)   state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase

    if (state_next != state_reg) cnt_next = '0;

    // Pin values are decoded from the state being entered so they are registered.
    lcd_e_next  = 1'b0;
    lcd_rs_next = 1'b0;
    lcd_d_next  = 4'd0;
    case (state_next)
      S_UP_SETUP, S_UP_HOLD: begin
        lcd_d_next  = data_next[7:4];
        lcd_rs_next = rs_next;
      end
      S_UP_EN: begin
        lcd_d_next  = data_next[7:4];
        lcd_rs_next = rs_next;
        lcd_e_next  = 1'b1;
      end
      S_GAP: lcd_rs_next = rs_next;
      S_LO_SETUP, S_LO_HOLD: begin
        lcd_d_next  = data_next[3:0];
        lcd_rs_next = rs_next;
      end
      S_LO_EN: begin
        lcd_d_next  = data_next[3:0];
        lcd_rs_next = rs_next;
        lcd_e_next  = 1'b1;
      end
      default: ;
    endcase

    done_next = (state_reg == S_WAIT) && (state_next == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      data_reg   <= 8'd0;
      rs_reg     <= 1'b0;
      nib_reg    <= 1'b0;
      long_reg   <= 1'b0;
      lcd_e_reg  <= 1'b0;
      lcd_rs_reg <= 1'b0;
      lcd_d_reg  <= 4'd0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      data_reg   <= data_next;
      rs_reg     <= rs_next;
      nib_reg    <= nib_next;
      long_reg   <= long_next;
      lcd_e_reg  <= lcd_e_next;
      lcd_rs_reg <= lcd_rs_next;
      lcd_d_reg  <= lcd_d_next;
      done_reg   <= done_next;
    end
  end

endmodule
